dispatch_queue: RTL and testbench

- Decoupling FIFO directly downstream of the frontend decode stage. Upstream of the ROB allocation port.
- Buffers decoded micro-ops (PC plus a packed uop bus) so a ROB stall does not back-pressure decode combinationally.
- Drops all buffered ops on branch redirect or trap.
- Fixed depth; strict in-order; one enqueue and one dequeue per cycle.

---
 rtl/dispatch_queue_if.sv | 13 +
 rtl/dispatch_queue.sv | 110 +++++++++++
 tb/tb_dispatch_queue.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/dispatch_queue_if.sv
// Handshake bundle for one side of the dispatch queue: valid/ready plus PC and packed uop.
// The master drives the payload, the slave drives ready.
interface dispatch_queue_if #(
  parameter int UOP_W = 128
);
  logic             valid;
  logic             ready;
  logic [31:0]      pc;
  logic [UOP_W-1:0] uop;

  modport master (output valid, output pc, output uop, input ready);
  modport slave  (input valid, input pc, input uop, output ready);
endinterface

// File: rtl/dispatch_queue.sv
// In-order decoupling FIFO between decode and ROB allocation; flush drops every buffered uop.
// Optional macro DISPATCH_QUEUE_PERF_EN adds full-stall and empty-cycle counters.
module dispatch_queue #(
  parameter int DEPTH = 4,
  parameter int UOP_W = 128
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       flush_i,
  dispatch_queue_if.slave            enq_if,
  dispatch_queue_if.master           deq_if,
`ifdef DISPATCH_QUEUE_PERF_EN
  output logic [31:0]                full_stall_cnt_o,
  output logic [31:0]                empty_cycle_cnt_o,
`endif
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int EW = 32 + UOP_W;
  localparam logic [PW-1:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [PW-1:0] rd_q, rd_d;
  logic [PW-1:0] wr_q, wr_d;
  logic [EW-1:0] mem_q [DEPTH];
  logic          full_s;
  logic          empty_s;
  logic          enq_s;
  logic          deq_s;
  logic [EW-1:0] head_s;

  // Pointers carry a wrap bit: same low bits with different wrap bit means full.
  assign full_s  = (wr_q[AW-1:0] == rd_q[AW-1:0]) && (wr_q[AW] != rd_q[AW]);
  assign empty_s = (wr_q == rd_q);
  assign enq_s   = enq_if.valid && !full_s && !flush_i;
  assign deq_s   = !empty_s && deq_if.ready && !flush_i;
  assign head_s  = mem_q[rd_q[AW-1:0]];

  assign enq_if.ready = !full_s;
  assign deq_if.valid = !empty_s && !flush_i;
  assign deq_if.pc    = head_s[EW-1:UOP_W];
  assign deq_if.uop   = head_s[UOP_W-1:0];
  assign count_o      = wr_q - rd_q;

  always_comb begin
    rd_d = rd_q;
    wr_d = wr_q;
    if (flush_i) begin
      rd_d = '0;
      wr_d = '0;
    end else begin
      if (enq_s) begin
        wr_d = wr_q + PTR_ONE;
      end else begin
        wr_d = wr_q;
      end
      if (deq_s) begin
        rd_d = rd_q + PTR_ONE;
      end else begin
        rd_d = rd_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_q <= '0;
      wr_q <= '0;
    end else begin
      rd_q <= rd_d;
      wr_q <= wr_d;
    end
  end

  // Storage is cleared on reset so the head reads zero; flush only rewinds the pointers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (enq_s) begin
      mem_q[wr_q[AW-1:0]] <= {enq_if.pc, enq_if.uop};
    end
  end

`ifdef DISPATCH_QUEUE_PERF_EN
  logic [31:0] full_stall_q;
  logic [31:0] empty_cycle_q;

  // Counters survive flush and wrap naturally at 2^32.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      full_stall_q  <= 32'd0;
      empty_cycle_q <= 32'd0;
    end else begin
      if (enq_if.valid && full_s) begin
        full_stall_q <= full_stall_q + 32'd1;
      end
      if (empty_s && !flush_i) begin
        empty_cycle_q <= empty_cycle_q + 32'd1;
      end
    end
  end

  assign full_stall_cnt_o  = full_stall_q;
  assign empty_cycle_cnt_o = empty_cycle_q;
`endif

endmodule

// File: tb/tb_dispatch_queue.sv
// Directed self-checking bench for dispatch_queue (DEPTH=4, UOP_W=128).
module tb_dispatch_queue;
  localparam int DEPTH = 4;
  localparam int UOP_W = 128;

  logic clk;
  logic rstn;
  logic flush_i;
  logic [2:0] count_o;
  int pass_cnt;
  int total_cnt;

  dispatch_queue_if #(.UOP_W(UOP_W)) enq_if ();
  dispatch_queue_if #(.UOP_W(UOP_W)) deq_if ();

`ifdef DISPATCH_QUEUE_PERF_EN
  logic [31:0] full_stall_cnt_o;
  logic [31:0] empty_cycle_cnt_o;
`endif

  dispatch_queue #(.DEPTH(DEPTH), .UOP_W(UOP_W)) dut (
    .clk     (clk),
    .rstn    (rstn),
    .flush_i (flush_i),
    .enq_if  (enq_if),
    .deq_if  (deq_if),
`ifdef DISPATCH_QUEUE_PERF_EN
    .full_stall_cnt_o  (full_stall_cnt_o),
    .empty_cycle_cnt_o (empty_cycle_cnt_o),
`endif
    .count_o (count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    enq_if.valid = 1'b0;
    enq_if.pc    = 32'd0;
    enq_if.uop   = '0;
    deq_if.ready = 1'b0;
    flush_i      = 1'b0;
    rstn         = 1'b0;
    #3;
    rstn = 1'b1;
    step();
  endtask

  task automatic drive(input logic v, input logic [31:0] pc);
    enq_if.valid = v;
    enq_if.pc    = pc;
    enq_if.uop   = {4{pc ^ 32'hA5A5_0000}};
  endtask

  task automatic test_reset();
    logic [127:0] exp_uop;
    do_reset();
    deq_if.ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 32'h0000_0010 + 32'(k));
      step();
    end
    drive(1'b0, 32'd0);
    #2;
    rstn = 1'b0;
    #1;
    total_cnt++; if (deq_if.valid !== 1'b0) $display("FAIL rst_valid got %0b want 0", deq_if.valid); else pass_cnt++;
    total_cnt++; if (count_o !== 3'd0) $display("FAIL rst_count got %0d want 0", count_o); else pass_cnt++;
    total_cnt++; if (enq_if.ready !== 1'b1) $display("FAIL rst_ready got %0b want 1", enq_if.ready); else pass_cnt++;
    total_cnt++; if (deq_if.pc !== 32'd0) $display("FAIL rst_pc got %h want 0", deq_if.pc); else pass_cnt++;
    rstn = 1'b1;
    step();
    drive(1'b1, 32'h8000_0000);
    step();
    drive(1'b0, 32'd0);
    exp_uop = {4{32'h8000_0000 ^ 32'hA5A5_0000}};
    total_cnt++; if (deq_if.valid !== 1'b1) $display("FAIL first_valid got %0b want 1", deq_if.valid); else pass_cnt++;
    total_cnt++; if (deq_if.pc !== 32'h8000_0000) $display("FAIL first_pc got %h want 80000000", deq_if.pc); else pass_cnt++;
    total_cnt++; if (deq_if.uop !== exp_uop) $display("FAIL first_uop got %h want %h", deq_if.uop, exp_uop); else pass_cnt++;
    total_cnt++; if (count_o !== 3'd1) $display("FAIL first_count got %0d want 1", count_o); else pass_cnt++;
  endtask

  task automatic test_fill_backpressure();
    logic [31:0] exp_pc [5];
    logic [2:0]  exp_cnt [5];
    exp_pc  = '{32'h100, 32'h104, 32'h108, 32'h10C, 32'h110};
    exp_cnt = '{3'd3, 3'd3, 3'd2, 3'd1, 3'd0};
    do_reset();
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 32'h100 + 32'(4 * k));
      step();
    end
    drive(1'b1, 32'h110);
    total_cnt++; if (enq_if.ready !== 1'b0) $display("FAIL full_ready got %0b want 0", enq_if.ready); else pass_cnt++;
    total_cnt++; if (count_o !== 3'd4) $display("FAIL full_count got %0d want 4", count_o); else pass_cnt++;
    step();
    total_cnt++; if (count_o !== 3'd4) $display("FAIL full_hold_count got %0d want 4", count_o); else pass_cnt++;
    deq_if.ready = 1'b1;
    // Cycle 0 is full: dequeue only; 0x110 lands on cycle 1.
    for (int i = 0; i < 5; i++) begin
      if (i >= 2) drive(1'b0, 32'd0);
      #1;
      total_cnt++; if (deq_if.valid !== 1'b1) $display("FAIL drain_valid[%0d] got %0b want 1", i, deq_if.valid); else pass_cnt++;
      total_cnt++; if (deq_if.pc !== exp_pc[i]) $display("FAIL drain_pc[%0d] got %h want %h", i, deq_if.pc, exp_pc[i]); else pass_cnt++;
      step();
      total_cnt++; if (count_o !== exp_cnt[i]) $display("FAIL drain_count[%0d] got %0d want %0d", i, count_o, exp_cnt[i]); else pass_cnt++;
    end
    deq_if.ready = 1'b0;
  endtask

  task automatic test_stream_wrap();
    logic [31:0] exp_pc;
    do_reset();
    deq_if.ready = 1'b1;
    for (int k = 0; k <= 10; k++) begin
      if (k < 10) drive(1'b1, 32'h200 + 32'(4 * k));
      else        drive(1'b0, 32'd0);
      #1;
      if (k > 0) begin
        exp_pc = 32'h200 + 32'(4 * (k - 1));
        total_cnt++; if (deq_if.valid !== 1'b1) $display("FAIL stream_valid[%0d] got %0b want 1", k, deq_if.valid); else pass_cnt++;
        total_cnt++; if (deq_if.pc !== exp_pc) $display("FAIL stream_pc[%0d] got %h want %h", k, deq_if.pc, exp_pc); else pass_cnt++;
        total_cnt++; if (deq_if.uop !== {4{exp_pc ^ 32'hA5A5_0000}}) $display("FAIL stream_uop[%0d] got %h", k, deq_if.uop); else pass_cnt++;
        total_cnt++; if (count_o !== 3'd1) $display("FAIL stream_count[%0d] got %0d want 1", k, count_o); else pass_cnt++;
      end
      step();
    end
    total_cnt++; if (count_o !== 3'd0) $display("FAIL stream_end_count got %0d want 0", count_o); else pass_cnt++;
    deq_if.ready = 1'b0;
  endtask

  task automatic test_flush();
    do_reset();
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 32'h0000_0030 + 32'(k));
      step();
    end
    drive(1'b1, 32'h300);
    deq_if.ready = 1'b1;
    flush_i = 1'b1;
    #1;
    total_cnt++; if (deq_if.valid !== 1'b0) $display("FAIL flush_valid got %0b want 0", deq_if.valid); else pass_cnt++;
    total_cnt++; if (enq_if.ready !== 1'b1) $display("FAIL flush_ready got %0b want 1", enq_if.ready); else pass_cnt++;
    step();
    flush_i = 1'b0;
    drive(1'b0, 32'd0);
    #1;
    total_cnt++; if (count_o !== 3'd0) $display("FAIL post_flush_count got %0d want 0", count_o); else pass_cnt++;
    total_cnt++; if (deq_if.valid !== 1'b0) $display("FAIL post_flush_valid got %0b want 0", deq_if.valid); else pass_cnt++;
    deq_if.ready = 1'b0;
    drive(1'b1, 32'h400);
    step();
    drive(1'b0, 32'd0);
    total_cnt++; if (deq_if.pc !== 32'h400) $display("FAIL post_flush_pc got %h want 400", deq_if.pc); else pass_cnt++;
    total_cnt++; if (count_o !== 3'd1) $display("FAIL post_flush_enq_count got %0d want 1", count_o); else pass_cnt++;
  endtask

`ifdef DISPATCH_QUEUE_PERF_EN
  task automatic test_perf();
    do_reset();
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 32'h500 + 32'(4 * k));
      step();
    end
    total_cnt++; if (full_stall_cnt_o !== 32'd0) $display("FAIL perf_stall_pre got %0d want 0", full_stall_cnt_o); else pass_cnt++;
    for (int k = 0; k < 4; k++) step();
    drive(1'b0, 32'd0);
    total_cnt++; if (full_stall_cnt_o !== 32'd4) $display("FAIL perf_stall got %0d want 4", full_stall_cnt_o); else pass_cnt++;
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    step();
    total_cnt++; if (full_stall_cnt_o !== 32'd4) $display("FAIL perf_stall_flush got %0d want 4", full_stall_cnt_o); else pass_cnt++;
    rstn = 1'b0;
    #1;
    total_cnt++; if (full_stall_cnt_o !== 32'd0) $display("FAIL perf_stall_rst got %0d want 0", full_stall_cnt_o); else pass_cnt++;
    rstn = 1'b1;
  endtask
`endif

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    rstn      = 1'b0;
    flush_i   = 1'b0;
    enq_if.valid = 1'b0;
    enq_if.pc    = 32'd0;
    enq_if.uop   = '0;
    deq_if.ready = 1'b0;
    #2;
    total_cnt++; if (enq_if.ready !== 1'b1) $display("FAIL init_ready got %0b want 1", enq_if.ready); else pass_cnt++;
    total_cnt++; if (deq_if.valid !== 1'b0) $display("FAIL init_valid got %0b want 0", deq_if.valid); else pass_cnt++;
    total_cnt++; if (deq_if.uop !== 128'd0) $display("FAIL init_uop got %h want 0", deq_if.uop); else pass_cnt++;
    test_reset();
    test_fill_backpressure();
    test_stream_wrap();
    test_flush();
`ifdef DISPATCH_QUEUE_PERF_EN
    test_perf();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
